// File: rtl/pwm_meter.sv
// pwm_meter: measures an incoming PWM waveform and reports its period, high
// time and duty on the same 0..2^N-1 code scale used by the fan PWM driver.
//
// Optional feature: define PWM_METER_GLITCH_FILTER_EN to insert a stability
// filter (FILT_LEN clocks) between the synchronizer and the edge detector.
//
// Parameters:
//   SYS_FREQ  system clock in MHz (sets the default TIMEOUT)
//   N         duty code width, full scale 2^N-1
//   CNT_W     period / high-time counter width
//   TIMEOUT   clocks without a rising edge before stall is declared
//   FILT_LEN  glitch filter stability length (filter build only)
//
// Ports:
//   clk        system clock
//   reset_p    synchronous active-high reset
//   pwm_in     asynchronous PWM input
//   duty       last measured duty code
//   period     last measured period in clocks
//   high_time  last measured high time in clocks
//   valid      one-clock pulse when duty/period/high_time update
//   stall      no rising edge seen within TIMEOUT clocks
//   overrun    sticky: a measurement was dropped because the divider was busy
module pwm_meter #(
  parameter int unsigned SYS_FREQ = 125,
  parameter int unsigned N        = 12,
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned TIMEOUT  = SYS_FREQ * 10000,
  parameter int unsigned FILT_LEN = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             pwm_in,
  output logic [N-1:0]     duty,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             stall,
  output logic             overrun
);

  localparam int unsigned NUM_W  = CNT_W + N;
  localparam int unsigned ITER_W = $clog2(N + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TMO       = CNT_W'(TIMEOUT);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N - 1);
  localparam logic [ITER_W-1:0] ITER_DONE = ITER_W'(N);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MEAS  = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  // Elaboration-time sanity check of the parameter set.
  if (SYS_FREQ == 0 || N < 2 || FILT_LEN == 0 || TIMEOUT <= N + 2 ||
      longint'(TIMEOUT) >= (longint'(1) << CNT_W) - longint'(1)) begin : g_bad_params
    $error("pwm_meter: illegal parameter combination");
  end

  // --------------------------------------------------------------------------
  // Input path: 2-FF synchronizer, optional stability filter, edge register
  // --------------------------------------------------------------------------
  logic sync1_q;
  logic sync2_q;
  logic lvl_c;
  logic lvl_q;
  logic rise_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      lvl_q   <= lvl_c;
      rise_q  <= lvl_c & ~lvl_q;
    end
  end

`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int unsigned FILT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_LEN - 1);

  logic              filt_q;
  logic [FILT_W-1:0] stab_q;

  // Filtered level follows the synced input only after FILT_LEN differing clocks.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == FILT_LAST) begin
      filt_q <= sync2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + FILT_W'(1);
    end
  end

  assign lvl_c = filt_q;
`else
  assign lvl_c = sync2_q;
`endif

  // --------------------------------------------------------------------------
  // Measurement FSM and divider state
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_p_q,    cnt_p_d;
  logic [CNT_W-1:0]  cnt_h_q,    cnt_h_d;
  logic              busy_q,     busy_d;
  logic [ITER_W-1:0] iter_q,     iter_d;
  logic [CNT_W-1:0]  rem_q,      rem_d;
  logic [N-1:0]      numlo_q,    numlo_d;
  logic [N-1:0]      quo_q,      quo_d;
  logic [CNT_W-1:0]  div_per_q,  div_per_d;
  logic [CNT_W-1:0]  div_high_q, div_high_d;
  logic [N-1:0]      duty_d;
  logic [CNT_W-1:0]  period_d;
  logic [CNT_W-1:0]  high_d;
  logic              valid_d;
  logic              stall_d;
  logic              overrun_d;

  logic [NUM_W-1:0]  num_c;
  logic [CNT_W:0]    trial_c;
  logic [CNT_W:0]    diff_c;
  logic              q_bit_c;
  logic [CNT_W-1:0]  cnt_p_inc_c;
  logic [CNT_W-1:0]  cnt_h_inc_c;
  logic              timeout_c;
  logic              restart_c;
  logic              start_c;
  logic              go_stall_c;

  // Next-state, counter, divider and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_p_d    = cnt_p_q;
    cnt_h_d    = cnt_h_q;
    busy_d     = busy_q;
    iter_d     = iter_q;
    rem_d      = rem_q;
    numlo_d    = numlo_q;
    quo_d      = quo_q;
    div_per_d  = div_per_q;
    div_high_d = div_high_q;
    duty_d     = duty;
    period_d   = period;
    high_d     = high_time;
    valid_d    = 1'b0;
    stall_d    = stall;
    overrun_d  = overrun;
    restart_c  = 1'b0;
    start_c    = 1'b0;
    go_stall_c = 1'b0;

    cnt_p_inc_c = (cnt_p_q == CNT_MAX) ? cnt_p_q : cnt_p_q + CNT_W'(1);
    cnt_h_inc_c = (cnt_h_q == CNT_MAX) ? cnt_h_q : cnt_h_q + CNT_W'(1);
    timeout_c   = (cnt_p_q >= TMO);

    // high * (2^N - 1) without a multiplier.
    num_c = (NUM_W'(cnt_h_q) << N) - NUM_W'(cnt_h_q);

    // One restoring step; rem < period keeps trial within CNT_W+1 bits,
    // so the borrow bit alone decides the quotient bit.
    trial_c = {rem_q, numlo_q[N-1]};
    diff_c  = trial_c - {1'b0, div_per_q};
    q_bit_c = ~diff_c[CNT_W];

    case (state_q)
      S_IDLE: begin
        if (rise_q) begin
          state_d   = S_MEAS;
          restart_c = 1'b1;
        end else if (timeout_c) begin
          go_stall_c = 1'b1;
        end else begin
          cnt_p_d = cnt_p_inc_c;
        end
      end
      S_MEAS: begin
        if (rise_q) begin
          restart_c = 1'b1;
          if (busy_q) begin
            overrun_d = 1'b1;
          end else begin
            start_c = 1'b1;
          end
        end else if (timeout_c) begin
          go_stall_c = 1'b1;
        end else begin
          cnt_p_d = cnt_p_inc_c;
          if (lvl_q) begin
            cnt_h_d = cnt_h_inc_c;
          end
        end
      end
      S_STALL: begin
        if (rise_q) begin
          state_d   = S_MEAS;
          restart_c = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Divider: N quotient bits MSB first, then one trailing cycle in which a
    // new rise is still refused, giving the N+2 clock minimum period.
    if (busy_q) begin
      if (iter_q == ITER_DONE) begin
        busy_d = 1'b0;
      end else begin
        rem_d   = q_bit_c ? diff_c[CNT_W-1:0] : trial_c[CNT_W-1:0];
        numlo_d = {numlo_q[N-2:0], 1'b0};
        quo_d   = {quo_q[N-2:0], q_bit_c};
        iter_d  = iter_q + ITER_W'(1);
        if (iter_q == ITER_LAST) begin
          duty_d   = {quo_q[N-2:0], q_bit_c};
          period_d = div_per_q;
          high_d   = div_high_q;
          valid_d  = 1'b1;
        end
      end
    end

    // A rise event is counted as the first clock of the new period.
    if (restart_c) begin
      cnt_p_d = CNT_W'(1);
      cnt_h_d = CNT_W'(lvl_q);
      stall_d = 1'b0;
    end

    if (start_c) begin
      busy_d     = 1'b1;
      iter_d     = '0;
      rem_d      = num_c[NUM_W-1:N];
      numlo_d    = num_c[N-1:0];
      quo_d      = '0;
      div_per_d  = cnt_p_q;
      div_high_d = cnt_h_q;
    end

    // Stall entry reports the static level and aborts any division in flight.
    if (go_stall_c) begin
      state_d  = S_STALL;
      stall_d  = 1'b1;
      duty_d   = lvl_q ? '1 : '0;
      period_d = '0;
      high_d   = '0;
      valid_d  = 1'b1;
      busy_d   = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q    <= S_IDLE;
      cnt_p_q    <= '0;
      cnt_h_q    <= '0;
      busy_q     <= 1'b0;
      iter_q     <= '0;
      rem_q      <= '0;
      numlo_q    <= '0;
      quo_q      <= '0;
      div_per_q  <= '0;
      div_high_q <= '0;
      duty       <= '0;
      period     <= '0;
      high_time  <= '0;
      valid      <= 1'b0;
      stall      <= 1'b1;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_p_q    <= cnt_p_d;
      cnt_h_q    <= cnt_h_d;
      busy_q     <= busy_d;
      iter_q     <= iter_d;
      rem_q      <= rem_d;
      numlo_q    <= numlo_d;
      quo_q      <= quo_d;
      div_per_q  <= div_per_d;
      div_high_q <= div_high_d;
      duty       <= duty_d;
      period     <= period_d;
      high_time  <= high_d;
      valid      <= valid_d;
      stall      <= stall_d;
      overrun    <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pwm_meter.sv
// tb_pwm_meter: directed bench for pwm_meter with a shortened TIMEOUT.
module tb_pwm_meter;

  localparam int unsigned N        = 12;
  localparam int unsigned CNT_W    = 24;
  localparam int unsigned T        = 4000;
  localparam int unsigned FILT_LEN = 8;
`ifdef PWM_METER_GLITCH_FILTER_EN
  localparam int LAT = 3 + FILT_LEN;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             reset_p;
  logic             pwm_in;
  logic [N-1:0]     duty;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             stall;
  logic             overrun;

  pwm_meter #(
    .SYS_FREQ(125),
    .N(N),
    .CNT_W(CNT_W),
    .TIMEOUT(T),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk),
    .reset_p(reset_p),
    .pwm_in(pwm_in),
    .duty(duty),
    .period(period),
    .high_time(high_time),
    .valid(valid),
    .stall(stall),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record of the most recent valid pulse.
  int          v_cnt = 0;
  int          v_cyc = -1;
  logic [31:0] v_duty = '0;
  logic [31:0] v_period = '0;
  logic [31:0] v_high = '0;
  logic [31:0] v_stall = '0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      v_cnt    <= v_cnt + 1;
      v_cyc    <= cyc;
      v_duty   <= 32'(duty);
      v_period <= 32'(period);
      v_high   <= 32'(high_time);
      v_stall  <= 32'(stall);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int last_rise = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pwm_run(input int per, input int hi, input int n);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      last_rise = cyc;
      ticks(hi);
      pwm_in = 1'b0;
      ticks(per - hi);
    end
  endtask

  task automatic wait_vcnt(input int target, input int budget, input string tag);
    int k;
    k = 0;
    while (v_cnt < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_wait"}, 32'(v_cnt >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r0;
    int c;
    int vc0;

    reset_p = 1'b1;
    pwm_in  = 1'b0;
    ticks(4);
    check("rst_duty",    32'(duty),      32'd0);
    check("rst_period",  32'(period),    32'd0);
    check("rst_high",    32'(high_time), 32'd0);
    check("rst_valid",   32'(valid),     32'd0);
    check("rst_stall",   32'(stall),     32'd1);
    check("rst_overrun", 32'(overrun),   32'd0);

    // Input held low: one stall report TIMEOUT+1 clocks after reset.
    reset_p = 1'b0;
    r0 = cyc;
    wait_vcnt(1, T + 100, "stall0");
    check("stall0_cyc",    32'(v_cyc), 32'(r0 + T + 1));
    check("stall0_duty",   v_duty,   32'd0);
    check("stall0_period", v_period, 32'd0);
    check("stall0_flag",   v_stall,  32'd1);
    ticks(50);
    check("stall0_once", 32'(v_cnt), 32'd1);
    check("stall0_hold", 32'(stall), 32'd1);

    // 50 % square wave: 1000*4095/2000 = 2047.5 -> 2047.
    vc0 = v_cnt;
    pwm_run(2000, 1000, 4);
    check("sq_count",  32'(v_cnt - vc0), 32'd3);
    check("sq_lat",    32'(v_cyc - last_rise), 32'(LAT + N + 1));
    check("sq_duty",   v_duty,   32'd2047);
    check("sq_period", v_period, 32'd2000);
    check("sq_high",   v_high,   32'd1000);
    check("sq_stall",  v_stall,  32'd0);

    // 250/1000 -> 1023; then 999/1000 -> 4090.
    vc0 = v_cnt;
    pwm_run(1000, 250, 3);
    check("q25_count",  32'(v_cnt - vc0), 32'd3);
    check("q25_duty",   v_duty,   32'd1023);
    check("q25_period", v_period, 32'd1000);
    check("q25_high",   v_high,   32'd250);
    pwm_run(1000, 999, 2);
    check("hi999_duty",   v_duty,   32'd4090);
    check("hi999_period", v_period, 32'd1000);
    check("hi999_high",   v_high,   32'd999);

    // Input stuck high: stall report with full-scale duty.
    vc0 = v_cnt;
    pwm_in = 1'b1;
    c = cyc;
    wait_vcnt(vc0 + 2, T + 100, "stuck");
    check("stuck_cyc",    32'(v_cyc), 32'(c + LAT + 1 + T));
    check("stuck_duty",   v_duty,   32'd4095);
    check("stuck_period", v_period, 32'd0);
    check("stuck_high",   v_high,   32'd0);
    check("stuck_stall",  32'(stall), 32'd1);

    // Recovery from stall: stall drops the cycle after the rise event.
    pwm_in = 1'b0;
    ticks(500);
    pwm_in = 1'b1;
    ticks(LAT);
    check("rec_stall_at_rise", 32'(stall), 32'd1);
    tick();
    check("rec_stall_clear", 32'(stall), 32'd0);
    ticks(300 - LAT - 1);
    pwm_in = 1'b0;
    ticks(700);
    vc0 = v_cnt;
    pwm_run(1000, 300, 2);
    check("rec_count",  32'(v_cnt - vc0), 32'd2);
    check("rec_duty",   v_duty,   32'd1228);
    check("rec_period", v_period, 32'd1000);
    check("rec_high",   v_high,   32'd300);

    // Too-short period sets the sticky overrun flag.
    check("ovr_clear", 32'(overrun), 32'd0);
    pwm_run(10, 5, 4);
    check("ovr_set", 32'(overrun), 32'd1);
    pwm_run(1000, 300, 2);
    check("ovr_sticky", 32'(overrun), 32'd1);

    // Reset in the middle of a division: no valid, reset values everywhere.
    pwm_in = 1'b1;
    ticks(LAT + 6);
    vc0 = v_cnt;
    reset_p = 1'b1;
    pwm_in  = 1'b0;
    ticks(3);
    reset_p = 1'b0;
    ticks(40);
    check("mid_rst_novalid", 32'(v_cnt - vc0), 32'd0);
    check("mid_rst_duty",    32'(duty),      32'd0);
    check("mid_rst_period",  32'(period),    32'd0);
    check("mid_rst_high",    32'(high_time), 32'd0);
    check("mid_rst_stall",   32'(stall),     32'd1);
    check("mid_rst_overrun", 32'(overrun),   32'd0);
    check("mid_rst_valid",   32'(valid),     32'd0);

    // 5-clock glitch inside a low phase.
    pwm_run(1000, 250, 3);
    vc0 = v_cnt;
    pwm_in = 1'b1;
    ticks(250);
    pwm_in = 1'b0;
    ticks(300);
    pwm_in = 1'b1;
    ticks(5);
    pwm_in = 1'b0;
    ticks(445);
`ifdef PWM_METER_GLITCH_FILTER_EN
    check("glitch_count",  32'(v_cnt - vc0), 32'd1);
    check("glitch_duty",   v_duty,   32'd1023);
    check("glitch_period", v_period, 32'd1000);
`else
    // Glitch is a rise: period 550, high 250 -> 1023750/550 = 1861.
    check("glitch_count",  32'(v_cnt - vc0), 32'd2);
    check("glitch_duty",   v_duty,   32'd1861);
    check("glitch_period", v_period, 32'd550);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
